clks_alot_half_rate_meter: RTL and testbench

- Downstream of the edge-recovery stage; consumes its rising/falling edge strobes, sampled in the system clock domain.
- Measures the high and low half-periods of the recovered clock in system cycles and checks each half against configured min/max bands.
- Tracks lock-in and produces the recovered_half_rates_s content plus locked status for the clock-state generator further downstream.

---
 rtl/clks_alot_half_rate_meter.sv | 225 ++++++++++++++++++++++
 tb/tb_clks_alot_half_rate_meter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/clks_alot_half_rate_meter.sv
// ---------------------------------------------------------------------------
// clks_alot_half_rate_meter
//
// Measures the high and low half-periods of a recovered clock, given as
// rising/falling edge strobes already sampled in the system clock domain.
// Each closed half is checked against a min/max band and feeds a lock-in
// counter. The rates and lock status feed the clock-state generator.
//
// Ports
//   clk_i, rst_n_i              system clock, async active-low reset
//   clear_i                     synchronous flush to IDLE (rates held)
//   rising_edge_i               recovered rising-edge strobe
//   falling_edge_i              recovered falling-edge strobe
//   even_50_50_en_i             judge the low half with the high-half band
//   lockin_enabled_i            report violations only once locked
//   lockin_rate_i               in-band halves needed to lock (0 acts as 1)
//   high/low_min/max_band_m1_i  band limits, encoded as cycles minus one
//   high_rate_o, low_rate_o     last measured half, cycles minus one
//   high_valid_o, low_valid_o   one-cycle pulse on a rate update
//   over_frequency_violation_o  pulse: half shorter than its minimum
//   under_frequency_violation_o pulse: half longer than its maximum/timeout
//   locked_o                    lock status
// ---------------------------------------------------------------------------
module clks_alot_half_rate_meter #(
    parameter int COUNTER_WIDTH = 32,
    parameter int LOCK_WIDTH    = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     clear_i,
    input  logic                     rising_edge_i,
    input  logic                     falling_edge_i,
    input  logic                     even_50_50_en_i,
    input  logic                     lockin_enabled_i,
    input  logic [LOCK_WIDTH-1:0]    lockin_rate_i,
    input  logic [COUNTER_WIDTH-1:0] high_min_band_m1_i,
    input  logic [COUNTER_WIDTH-1:0] high_max_band_m1_i,
    input  logic [COUNTER_WIDTH-1:0] low_min_band_m1_i,
    input  logic [COUNTER_WIDTH-1:0] low_max_band_m1_i,
    output logic [COUNTER_WIDTH-1:0] high_rate_o,
    output logic [COUNTER_WIDTH-1:0] low_rate_o,
    output logic                     high_valid_o,
    output logic                     low_valid_o,
    output logic                     over_frequency_violation_o,
    output logic                     under_frequency_violation_o,
    output logic                     locked_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2
    } state_t;

    typedef struct packed {
        logic [COUNTER_WIDTH-1:0] min_m1;
        logic [COUNTER_WIDTH-1:0] max_m1;
    } band_t;

    state_t                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNTER_WIDTH-1:0] high_rate_q, high_rate_d;
    logic [COUNTER_WIDTH-1:0] low_rate_q, low_rate_d;
    logic [LOCK_WIDTH-1:0]    lock_cnt_q, lock_cnt_d;
    logic                     high_vld_q, high_vld_d;
    logic                     low_vld_q, low_vld_d;
    logic                     over_q, over_d;
    logic                     under_q, under_d;
    logic                     locked_q, locked_d;

    // Simultaneous strobes carry no usable direction and are dropped.
    logic rise, fall;
    assign rise = rising_edge_i & ~falling_edge_i;
    assign fall = falling_edge_i & ~rising_edge_i;

    logic in_high, in_low;
    assign in_high = (state_q == MEAS_HIGH);
    assign in_low  = (state_q == MEAS_LOW);

    // Band for the half currently being measured.
    band_t band;
    always_comb begin
        if (in_high || even_50_50_en_i) begin
            band.min_m1 = high_min_band_m1_i;
            band.max_m1 = high_max_band_m1_i;
        end else begin
            band.min_m1 = low_min_band_m1_i;
            band.max_m1 = low_max_band_m1_i;
        end
    end

    logic too_short, too_long;
    assign too_short = (cnt_q < band.min_m1);
    assign too_long  = (cnt_q > band.max_m1);

    // Timeout threshold is max_m1+1, computed one bit wider so an all-ones
    // max never wraps into a spurious early timeout. A >= test also catches
    // a counter already past a freshly lowered limit.
    logic [COUNTER_WIDTH:0] max_p1;
    logic                   timeout;
    assign max_p1  = {1'b0, band.max_m1} + {{COUNTER_WIDTH{1'b0}}, 1'b1};
    assign timeout = ({1'b0, cnt_q} >= max_p1);

    logic [COUNTER_WIDTH-1:0] cnt_inc;
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    logic [LOCK_WIDTH-1:0] lock_inc, rate_eff;
    assign lock_inc = (&lock_cnt_q) ? lock_cnt_q : lock_cnt_q + 1'b1;
    assign rate_eff = (lockin_rate_i == '0) ? {{(LOCK_WIDTH-1){1'b0}}, 1'b1}
                                            : lockin_rate_i;

    // Violations are gated on the lock status held before this event.
    logic report;
    assign report = ~lockin_enabled_i | locked_q;

    logic close_half, repeat_edge;
    assign close_half  = (in_high & fall) | (in_low & rise);
    assign repeat_edge = (in_high & rise) | (in_low & fall);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_inc;
        high_rate_d = high_rate_q;
        low_rate_d  = low_rate_q;
        lock_cnt_d  = lock_cnt_q;
        locked_d    = locked_q;
        high_vld_d  = 1'b0;
        low_vld_d   = 1'b0;
        over_d      = 1'b0;
        under_d     = 1'b0;

        if (clear_i) begin
            state_d    = IDLE;
            cnt_d      = '0;
            lock_cnt_d = '0;
            locked_d   = 1'b0;
        end else begin
            unique case (state_q)
                MEAS_HIGH, MEAS_LOW: begin
                    if (close_half) begin
                        if (in_high) begin
                            high_rate_d = cnt_q;
                            high_vld_d  = 1'b1;
                            state_d     = MEAS_LOW;
                        end else begin
                            low_rate_d  = cnt_q;
                            low_vld_d   = 1'b1;
                            state_d     = MEAS_HIGH;
                        end
                        cnt_d = '0;
                        if (too_short || too_long) begin
                            over_d     = too_short & report;
                            under_d    = too_long & report;
                            lock_cnt_d = '0;
                            locked_d   = 1'b0;
                        end else begin
                            lock_cnt_d = lock_inc;
                            locked_d   = locked_q | (lock_inc >= rate_eff);
                        end
                    end else if (repeat_edge) begin
                        // Missing opposite edge: restart the half, drop lock.
                        cnt_d      = '0;
                        over_d     = report;
                        lock_cnt_d = '0;
                        locked_d   = 1'b0;
                    end else if (timeout) begin
                        state_d    = IDLE;
                        cnt_d      = '0;
                        under_d    = report;
                        lock_cnt_d = '0;
                        locked_d   = 1'b0;
                    end
                end
                default: begin
                    // IDLE: first edge only establishes the reference.
                    cnt_d = '0;
                    if (rise) begin
                        state_d = MEAS_HIGH;
                    end else if (fall) begin
                        state_d = MEAS_LOW;
                    end
                end
            endcase
        end

        if (!lockin_enabled_i) begin
            locked_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            high_rate_q <= '0;
            low_rate_q  <= '0;
            lock_cnt_q  <= '0;
            locked_q    <= 1'b0;
            high_vld_q  <= 1'b0;
            low_vld_q   <= 1'b0;
            over_q      <= 1'b0;
            under_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            high_rate_q <= high_rate_d;
            low_rate_q  <= low_rate_d;
            lock_cnt_q  <= lock_cnt_d;
            locked_q    <= locked_d;
            high_vld_q  <= high_vld_d;
            low_vld_q   <= low_vld_d;
            over_q      <= over_d;
            under_q     <= under_d;
        end
    end

    assign high_rate_o                 = high_rate_q;
    assign low_rate_o                  = low_rate_q;
    assign high_valid_o                = high_vld_q;
    assign low_valid_o                 = low_vld_q;
    assign over_frequency_violation_o  = over_q;
    assign under_frequency_violation_o = under_q;
    assign locked_o                    = locked_q;

endmodule

// File: tb/tb_clks_alot_half_rate_meter.sv
// ---------------------------------------------------------------------------
// tb_clks_alot_half_rate_meter
//
// Directed stimulus pushes hand-computed expectations (cycle of the pulse,
// pulse flags, lock status, rates) into a queue; a monitor on the falling
// clock edge pops and compares whenever any output pulse is present.
// ---------------------------------------------------------------------------
module tb_clks_alot_half_rate_meter;

    localparam int CW = 32;
    localparam int LW = 8;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          clear_i = 1'b0;
    logic          rising_edge_i = 1'b0;
    logic          falling_edge_i = 1'b0;
    logic          even_50_50_en_i = 1'b0;
    logic          lockin_enabled_i = 1'b1;
    logic [LW-1:0] lockin_rate_i = 8'd3;
    logic [CW-1:0] high_min_band_m1_i = 32'd3;
    logic [CW-1:0] high_max_band_m1_i = 32'd5;
    logic [CW-1:0] low_min_band_m1_i = 32'd3;
    logic [CW-1:0] low_max_band_m1_i = 32'd5;
    logic [CW-1:0] high_rate_o, low_rate_o;
    logic          high_valid_o, low_valid_o;
    logic          over_frequency_violation_o, under_frequency_violation_o;
    logic          locked_o;

    clks_alot_half_rate_meter #(.COUNTER_WIDTH(CW), .LOCK_WIDTH(LW)) dut (
        .clk_i                       (clk_i),
        .rst_n_i                     (rst_n_i),
        .clear_i                     (clear_i),
        .rising_edge_i               (rising_edge_i),
        .falling_edge_i              (falling_edge_i),
        .even_50_50_en_i             (even_50_50_en_i),
        .lockin_enabled_i            (lockin_enabled_i),
        .lockin_rate_i               (lockin_rate_i),
        .high_min_band_m1_i          (high_min_band_m1_i),
        .high_max_band_m1_i          (high_max_band_m1_i),
        .low_min_band_m1_i           (low_min_band_m1_i),
        .low_max_band_m1_i           (low_max_band_m1_i),
        .high_rate_o                 (high_rate_o),
        .low_rate_o                  (low_rate_o),
        .high_valid_o                (high_valid_o),
        .low_valid_o                 (low_valid_o),
        .over_frequency_violation_o  (over_frequency_violation_o),
        .under_frequency_violation_o (under_frequency_violation_o),
        .locked_o                    (locked_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        bit            hv, lv, ov, un, lk;
        logic [CW-1:0] hr, lr;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;
    logic [CW-1:0] exp_hr = '0;
    logic [CW-1:0] exp_lr = '0;

    task automatic push(input int c, input bit hv, input bit lv, input bit ov,
                        input bit un, input bit lk);
        exp_t e;
        e.cyc = c; e.hv = hv; e.lv = lv; e.ov = ov; e.un = un; e.lk = lk;
        e.hr = exp_hr; e.lr = exp_lr;
        exp_q.push_back(e);
    endtask

    // Monitor: any pulse must match the next queued expectation exactly.
    always @(negedge clk_i) begin
        if (rst_n_i && (high_valid_o || low_valid_o ||
                        over_frequency_violation_o || under_frequency_violation_o)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse cyc=%0d hv=%0b lv=%0b ov=%0b un=%0b",
                         cyc, high_valid_o, low_valid_o,
                         over_frequency_violation_o, under_frequency_violation_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (cyc != e.cyc || high_valid_o != e.hv || low_valid_o != e.lv ||
                    over_frequency_violation_o != e.ov ||
                    under_frequency_violation_o != e.un || locked_o != e.lk ||
                    high_rate_o != e.hr || low_rate_o != e.lr) begin
                    bad++;
                    $display("FAIL pulse got cyc=%0d hv%0b lv%0b ov%0b un%0b lk%0b hr=%0d lr=%0d want cyc=%0d hv%0b lv%0b ov%0b un%0b lk%0b hr=%0d lr=%0d",
                             cyc, high_valid_o, low_valid_o, over_frequency_violation_o,
                             under_frequency_violation_o, locked_o, high_rate_o, low_rate_o,
                             e.cyc, e.hv, e.lv, e.ov, e.un, e.lk, e.hr, e.lr);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [CW-1:0] got, input logic [CW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // One-cycle strobe; returns 1ns after the sampling edge, where any
    // resulting registered output is already visible.
    task automatic step(input logic r, input logic f);
        rising_edge_i  = r;
        falling_edge_i = f;
        @(posedge clk_i); #1;
        rising_edge_i  = 1'b0;
        falling_edge_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    int e_t;

    initial begin
        // Reset state
        #12;
        chk("rst_high_rate", high_rate_o, 0);
        chk("rst_low_rate", low_rate_o, 0);
        chk("rst_locked", {31'd0, locked_o}, 0);
        chk("rst_pulses", {28'd0, high_valid_o, low_valid_o,
                           over_frequency_violation_o, under_frequency_violation_o}, 0);
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        idle(2);

        // 1: 5-cycle halves, lock on the 3rd in-band half
        step(1, 0);
        idle(4); step(0, 1); exp_hr = 4; push(cyc, 1, 0, 0, 0, 0);
        idle(4); step(1, 0); exp_lr = 4; push(cyc, 0, 1, 0, 0, 0);
        idle(4); step(0, 1);             push(cyc, 1, 0, 0, 0, 1);
        idle(4); step(1, 0);             push(cyc, 0, 1, 0, 0, 1);

        // 2: 2-cycle high half while locked -> over, lock drops
        idle(1); step(0, 1); exp_hr = 1; push(cyc, 1, 0, 1, 0, 0);

        // 5: low half in band, then simultaneous strobes ignored mid-high
        idle(4); step(1, 0); exp_lr = 4; push(cyc, 0, 1, 0, 0, 0);
        idle(1); step(1, 1);
        idle(2); step(0, 1); exp_hr = 4; push(cyc, 1, 0, 0, 0, 0);

        // 3: lock-in off, rising then silence -> timeout at counter=6
        lockin_enabled_i = 1'b0;
        idle(4); step(1, 0); exp_lr = 4; push(cyc, 0, 1, 0, 0, 0);
        e_t = cyc;
        push(e_t + 7, 0, 0, 0, 1, 0);
        idle(9);
        step(0, 1);
        chk("idle_fall_no_valid", {30'd0, high_valid_o, low_valid_o}, 0);

        // 4: even 50/50 judges the low half with high limits
        low_min_band_m1_i = 32'd10;
        low_max_band_m1_i = 32'd20;
        even_50_50_en_i   = 1'b1;
        idle(4); step(1, 0); exp_lr = 4; push(cyc, 0, 1, 0, 0, 0);
        idle(4); step(0, 1); exp_hr = 4; push(cyc, 1, 0, 0, 0, 0);
        even_50_50_en_i   = 1'b0;
        idle(4); step(1, 0); exp_lr = 4; push(cyc, 0, 1, 1, 0, 0);
        // Closing edge on the same cycle the timeout would fire: measured 6
        idle(6); step(0, 1); exp_hr = 6; push(cyc, 1, 0, 0, 1, 0);

        // 6: re-lock with 4-cycle halves (min boundary), then clear and reset
        low_min_band_m1_i = 32'd3;
        low_max_band_m1_i = 32'd5;
        lockin_enabled_i  = 1'b1;
        idle(3); step(1, 0); exp_lr = 3; push(cyc, 0, 1, 0, 0, 0);
        idle(3); step(0, 1); exp_hr = 3; push(cyc, 1, 0, 0, 0, 0);
        idle(3); step(1, 0); exp_lr = 3; push(cyc, 0, 1, 0, 0, 1);
        chk("locked_before_clear", {31'd0, locked_o}, 1);
        idle(2);
        clear_i = 1'b1;
        @(posedge clk_i); #1;
        clear_i = 1'b0;
        chk("clear_locked", {31'd0, locked_o}, 0);
        chk("clear_high_rate_held", high_rate_o, 3);
        chk("clear_low_rate_held", low_rate_o, 3);
        // In IDLE a rising edge only sets the reference
        idle(2); step(1, 0);
        chk("post_clear_rise_no_valid", {30'd0, high_valid_o, low_valid_o}, 0);
        idle(4); step(0, 1); exp_hr = 4; push(cyc, 1, 0, 0, 0, 0);

        // Async reset mid-half
        idle(2);
        #2 rst_n_i = 1'b0;
        #1;
        chk("async_rst_high_rate", high_rate_o, 0);
        chk("async_rst_low_rate", low_rate_o, 0);
        chk("async_rst_locked", {31'd0, locked_o}, 0);
        idle(2);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_pulses got=0 want=%0d", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
